// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for a shared combinational ALU
// One operation in flight at a time: IDLE accepts, EXEC drives the ALU, RESP holds the result.
package alu_arbiter_pkg;
  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_XOR = 4'b0011,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_control_t;
endpackage

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  alu_control_t req0_control,
  input  alu_control_t req1_control,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output alu_control_t alu_control,
  input  logic [N-1:0] alu_result,
  input  logic         alu_overflow,
  input  logic         alu_zero,
  input  logic         alu_equal,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [N-1:0] resp_result,
  output logic         resp_overflow,
  output logic         resp_zero,
  output logic         resp_equal,
  output logic [15:0]  ops_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       state_q;
  logic         ptr_q;
  logic [N-1:0] a_q;
  logic [N-1:0] b_q;
  alu_control_t ctrl_q;
  logic         id_q;
  logic         resp_valid_q;
  logic [N-1:0] resp_result_q;
  logic         resp_overflow_q;
  logic         resp_zero_q;
  logic         resp_equal_q;
  logic [15:0]  ops_done_q;
  logic [15:0]  ops_done_d;

  logic idle;
  logic grant1;
  logic accept;

  // A lone valid wins outright; the pointer only breaks ties.
  assign idle       = (state_q == IDLE);
  assign grant1     = req1_valid && (!req0_valid || ptr_q);
  assign req1_ready = idle && grant1;
  assign req0_ready = idle && req0_valid && !grant1;
  assign accept     = req0_ready || req1_ready;

  assign ops_done_d = (state_q == RESP && resp_ready) ? ops_done_q + 16'd1 : ops_done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      ptr_q           <= 1'b0;
      a_q             <= '0;
      b_q             <= '0;
      ctrl_q          <= ALU_AND;
      id_q            <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_result_q   <= '0;
      resp_overflow_q <= 1'b0;
      resp_zero_q     <= 1'b0;
      resp_equal_q    <= 1'b0;
      ops_done_q      <= 16'd0;
    end else begin
      ops_done_q <= ops_done_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= grant1 ? req1_a : req0_a;
            b_q     <= grant1 ? req1_b : req0_b;
            ctrl_q  <= grant1 ? req1_control : req0_control;
            id_q    <= grant1;
            ptr_q   <= !grant1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          resp_result_q   <= alu_result;
          resp_overflow_q <= alu_overflow;
          resp_zero_q     <= alu_zero;
          resp_equal_q    <= alu_equal;
          resp_valid_q    <= 1'b1;
          state_q         <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ALU inputs always come from the latched operands, so they never follow requester inputs.
  assign alu_a         = a_q;
  assign alu_b         = b_q;
  assign alu_control   = ctrl_q;
  assign resp_valid    = resp_valid_q;
  assign resp_id       = id_q;
  assign resp_result   = resp_result_q;
  assign resp_overflow = resp_overflow_q;
  assign resp_zero     = resp_zero_q;
  assign resp_equal    = resp_equal_q;
  assign ops_done      = ops_done_q;

endmodule
